// File: rtl/uart_alu_interface.sv
// Frame collector between the UART FIFOs and an external combinational ALU.
// Gathers A, B and opcode bytes, latches the ALU result and pushes it to the tx FIFO.
module uart_alu_interface #(
  parameter int DBIT    = 8,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_empty,
  input  logic [DBIT-1:0] i_r_data,
  output logic            o_rd_uart,
  input  logic            i_tx_full,
  output logic            o_wr_uart,
  output logic [DBIT-1:0] o_w_data,
  output logic [DBIT-1:0] o_alu_a,
  output logic [DBIT-1:0] o_alu_b,
  output logic [OP_W-1:0] o_alu_op,
  input  logic [DBIT-1:0] i_alu_result,
  output logic            o_busy,
  output logic            o_frame_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND} state_t;

  state_t          state, state_nxt;
  logic [DBIT-1:0] a_q, b_q, res_q;
  logic [OP_W-1:0] op_q;
  logic [CW-1:0]   tmo_q;
  logic            rd, wr, ferr, tmo_clr, tmo_inc;

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    wr        = 1'b0;
    ferr      = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    case (state)
      WAIT_A: if (!i_rx_empty) begin
        rd        = 1'b1;
        tmo_clr   = 1'b1;
        state_nxt = WAIT_B;
      end
      WAIT_B, WAIT_OP: begin
        // An available byte always beats the timeout, even in the expiry cycle.
        if (!i_rx_empty) begin
          rd        = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = (state == WAIT_B) ? WAIT_OP : COMPUTE;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          ferr      = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = WAIT_A;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      COMPUTE: state_nxt = SEND;
      SEND: if (!i_tx_full) begin
        wr        = 1'b1;
        state_nxt = WAIT_A;
      end
      default: state_nxt = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= WAIT_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      tmo_q <= '0;
    end else begin
      state <= state_nxt;
      if (rd) begin
        case (state)
          WAIT_A:  a_q  <= i_r_data;
          WAIT_B:  b_q  <= i_r_data;
          WAIT_OP: op_q <= i_r_data[OP_W-1:0];
          default: ;
        endcase
      end
      if (state == COMPUTE) res_q <= i_alu_result;
      if (tmo_clr)      tmo_q <= '0;
      else if (tmo_inc) tmo_q <= tmo_q + 1'b1;
    end
  end

  // Strobes are combinational, so mask them while reset is asserted.
  assign o_rd_uart   = rd   & ~i_reset;
  assign o_wr_uart   = wr   & ~i_reset;
  assign o_frame_err = ferr & ~i_reset;
  assign o_busy      = (state != WAIT_A) & ~i_reset;
  assign o_w_data    = res_q;
  assign o_alu_a     = a_q;
  assign o_alu_b     = b_q;
  assign o_alu_op    = op_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: rx FIFO model, ALU model and a tx-result scoreboard.
module tb_uart_alu_interface;
  localparam int DBIT = 8, OP_W = 6, TMO = 16;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_rx_empty;
  logic [DBIT-1:0] i_r_data;
  logic            o_rd_uart;
  logic            i_tx_full = 1'b0;
  logic            o_wr_uart;
  logic [DBIT-1:0] o_w_data, o_alu_a, o_alu_b;
  logic [OP_W-1:0] o_alu_op;
  logic [DBIT-1:0] i_alu_result;
  logic            o_busy, o_frame_err;

  uart_alu_interface #(.DBIT(DBIT), .OP_W(OP_W), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_empty(i_rx_empty), .i_r_data(i_r_data),
    .o_rd_uart(o_rd_uart), .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart),
    .o_w_data(o_w_data), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  // rx FIFO model: pushed by the stimulus, popped on o_rd_uart
  logic [DBIT-1:0] rx_mem [256];
  int rx_wr = 0, rx_rd = 0;
  assign i_rx_empty = (rx_wr == rx_rd);
  assign i_r_data   = rx_mem[rx_rd[7:0]];
  always @(posedge i_clk) if (o_rd_uart) rx_rd <= rx_rd + 1;

  // external ALU model
  always_comb begin
    case (o_alu_op)
      6'h20:   i_alu_result = o_alu_a + o_alu_b;
      6'h22:   i_alu_result = o_alu_a - o_alu_b;
      6'h24:   i_alu_result = o_alu_a & o_alu_b;
      6'h25:   i_alu_result = o_alu_a | o_alu_b;
      default: i_alu_result = 8'hEE;
    endcase
  end

  int checks = 0, errors = 0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, ferr_cnt = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0, last_ferr_cyc = 0;
  logic [DBIT-1:0] expq [$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor / scoreboard, sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_rd_uart) begin rd_cnt++; last_rd_cyc = cyc; end
    if (o_frame_err) begin ferr_cnt++; last_ferr_cyc = cyc; end
    if (o_rd_uart && o_wr_uart) check("rd_wr_overlap", 1, 0);
    if (o_wr_uart) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (expq.size() == 0) check("unexpected_write", {24'h0, o_w_data}, 32'hFFFF_FFFF);
      else check("w_data", {24'h0, o_w_data}, {24'h0, expq.pop_front()});
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic push(input logic [DBIT-1:0] b);
    rx_mem[rx_wr[7:0]] = b;
    rx_wr++;
  endtask

  task automatic wait_rd(input int target, input string tag);
    int n = 0;
    while (rd_cnt < target && n < 200) begin tick(); n++; end
    check(tag, rd_cnt, target);
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n = 0;
    while (wr_cnt < target && n < 200) begin tick(); n++; end
    check(tag, wr_cnt, target);
  endtask

  initial begin
    int rd0, w0, f0, bcyc, rel;
    // reset
    tick(); tick();
    check("reset_rd_strobe", o_rd_uart, 0);
    i_reset = 1'b0;
    check("reset_busy", o_busy, 0);
    check("reset_wr", o_wr_uart, 0);
    check("reset_ferr", o_frame_err, 0);
    check("reset_alu_a", o_alu_a, 0);
    check("reset_alu_b", o_alu_b, 0);
    check("reset_alu_op", o_alu_op, 0);
    check("reset_w_data", o_w_data, 0);

    // basic frame
    push(8'h05); push(8'h03); push(8'h20); expq.push_back(8'h08);
    wait_wr(1, "basic_write");
    check("basic_pops", rd_cnt, 3);
    check("basic_alu_a", o_alu_a, 8'h05);
    check("basic_alu_b", o_alu_b, 8'h03);
    check("basic_alu_op", o_alu_op, 6'h20);
    check("basic_latency", last_wr_cyc - last_rd_cyc, 2);
    tick(); tick();
    check("w_data_hold", o_w_data, 8'h08);
    check("basic_single_write", wr_cnt, 1);

    // back-to-back frames
    rel = cyc;
    push(8'h0A); push(8'h04); push(8'h22); expq.push_back(8'h06);
    push(8'hF0); push(8'h0F); push(8'h25); expq.push_back(8'hFF);
    wait_wr(3, "b2b_writes");
    check("b2b_pops", rd_cnt, 9);
    check("b2b_span", last_wr_cyc - rel, 9);

    // tx stall
    i_tx_full = 1'b1;
    rd0 = rd_cnt; w0 = wr_cnt;
    push(8'h02); push(8'h03); push(8'h20); expq.push_back(8'h05);
    wait_rd(rd0 + 3, "stall_pops");
    push(8'h09); push(8'h01); push(8'h20); expq.push_back(8'h0A);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("stall_busy", o_busy, 1);
    end
    check("stall_no_rx", rd_cnt, rd0 + 3);
    check("stall_no_write", wr_cnt, w0);
    i_tx_full = 1'b0;
    rel = cyc;
    tick();
    check("stall_release_write", wr_cnt, w0 + 1);
    check("stall_release_cycle", last_wr_cyc, rel);
    wait_wr(w0 + 2, "stall_next_frame");

    // timeout
    tick();
    rd0 = rd_cnt; f0 = ferr_cnt; w0 = wr_cnt;
    push(8'h07); push(8'h02);
    wait_rd(rd0 + 2, "tmo_pops");
    bcyc = last_rd_cyc;
    for (int i = 0; i < 30 && ferr_cnt == f0; i++) tick();
    check("tmo_ferr_seen", ferr_cnt, f0 + 1);
    check("tmo_ferr_delay", last_ferr_cyc - bcyc, TMO);
    check("tmo_back_idle", o_busy, 0);
    repeat (20) tick();
    check("tmo_ferr_once", ferr_cnt, f0 + 1);
    check("tmo_no_write", wr_cnt, w0);
    push(8'h01); push(8'h01); push(8'h20); expq.push_back(8'h02);
    wait_wr(w0 + 1, "tmo_recover_write");

    // timeout boundary: opcode appears exactly in the expiry cycle
    tick();
    rd0 = rd_cnt; f0 = ferr_cnt; w0 = wr_cnt;
    push(8'h07); push(8'h02);
    wait_rd(rd0 + 2, "bnd_pops");
    bcyc = last_rd_cyc;
    while (cyc < bcyc + TMO) tick();
    push(8'h20); expq.push_back(8'h09);
    wait_wr(w0 + 1, "bnd_write");
    check("bnd_pop_cycle", last_rd_cyc - bcyc, TMO);
    check("bnd_no_ferr", ferr_cnt, f0);

    // reset mid-frame
    tick();
    rd0 = rd_cnt; w0 = wr_cnt;
    push(8'h0A); push(8'h0B);
    wait_rd(rd0 + 2, "rst_pops");
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("rst_alu_a", o_alu_a, 0);
    check("rst_alu_b", o_alu_b, 0);
    check("rst_alu_op", o_alu_op, 0);
    check("rst_w_data", o_w_data, 0);
    check("rst_busy", o_busy, 0);
    push(8'h03); push(8'h04); push(8'h20); expq.push_back(8'h07);
    wait_wr(w0 + 1, "rst_write");
    check("rst_alu_a_new", o_alu_a, 8'h03);
    check("rst_alu_b_new", o_alu_b, 8'h04);

    repeat (5) tick();
    check("scoreboard_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
